// File: rtl/fp32_mac_pkg.sv
// Shared types, constants and the FP32 round-and-pack helper for the fp32_mac_vec block.
package fp32_mac_pkg;

    localparam int unsigned FP32_W    = 32;
    localparam logic [31:0] FP32_ZERO = 32'h00000000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {StIdle, StCalc, StHold} mac_state_e;

    function automatic logic fp32_is_nan(input logic [31:0] a);
        return (&a[30:23]) && (|a[22:0]);
    endfunction

    function automatic logic fp32_is_inf(input logic [31:0] a);
        return (&a[30:23]) && !(|a[22:0]);
    endfunction

    function automatic logic fp32_is_zero(input logic [31:0] a);
        return !(|a[30:0]);
    endfunction

    // Operand value is sig * 2^(exp - 150); subnormals use exponent 1 with no hidden bit.
    function automatic int fp32_exp(input logic [31:0] a);
        return (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    endfunction

    function automatic logic [23:0] fp32_sig(input logic [31:0] a);
        return {|a[30:23], a[22:0]};
    endfunction

    // Rounds m * 2^e to nearest-even FP32; m is non-zero and may carry a sticky LSB.
    function automatic logic [31:0] fp32_round_pack(input logic sgn, input int e,
                                                    input logic [49:0] m);
        int          p;
        int          q;
        int          s;
        logic [63:0] mm;
        logic [63:0] kept;
        logic [63:0] rem;
        logic [63:0] half;
        logic [7:0]  ex;
        p = 0;
        for (int i = 0; i < 50; i++) begin
            if (m[i]) p = i;
        end
        q = e + p - 23;
        if (q < -149) q = -149;
        s = q - e;
        if (s > 60) s = 60;
        mm = {14'd0, m};
        if (s > 0) begin
            kept = mm >> s;
            rem  = mm & ((64'd1 << s) - 64'd1);
            half = 64'd1 << (s - 1);
            if ((rem > half) || ((rem == half) && kept[0])) kept = kept + 64'd1;
        end else begin
            kept = mm << (-s);
        end
        if (kept[24]) begin
            kept = kept >> 1;
            q    = q + 1;
        end
        if (q + 150 >= 255) return {sgn, 8'hFF, 23'd0};
        ex = kept[23] ? 8'(q + 150) : 8'd0;
        return {sgn, ex, kept[22:0]};
    endfunction

endpackage

// File: rtl/fp32_mac_lane.sv
// One combinational FP32 MAC lane: multiply, clear mux, add; NaN/Inf detect when
// FP32_MAC_STATUS_EN is defined.
module fp32_mac_lane
    import fp32_mac_pkg::*;
(
    input  logic [FP32_W-1:0] alpha_i,
    input  logic [FP32_W-1:0] bravo_i,
    input  logic [FP32_W-1:0] acc_i,
    input  logic              clear_i,
`ifdef FP32_MAC_STATUS_EN
    output logic              nan_o,
    output logic              inf_o,
`endif
    output logic [FP32_W-1:0] sum_o
);

    function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [47:0] prod;
        sgn = a[31] ^ b[31];
        if (fp32_is_nan(a) || fp32_is_nan(b) || (fp32_is_inf(a) && fp32_is_zero(b)) ||
            (fp32_is_inf(b) && fp32_is_zero(a))) return FP32_QNAN;
        if (fp32_is_inf(a) || fp32_is_inf(b)) return {sgn, 8'hFF, 23'd0};
        if (fp32_is_zero(a) || fp32_is_zero(b)) return {sgn, 31'd0};
        prod = 48'(fp32_sig(a)) * 48'(fp32_sig(b));
        return fp32_round_pack(sgn, fp32_exp(a) + fp32_exp(b) - 300, {2'd0, prod});
    endfunction

    // Three guard bits plus a sticky LSB are enough for correct RNE on add and subtract.
    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] big;
        logic [31:0] sml;
        logic [26:0] mb;
        logic [26:0] ms;
        logic [27:0] sum;
        int          d;
        if (fp32_is_nan(a) || fp32_is_nan(b) ||
            (fp32_is_inf(a) && fp32_is_inf(b) && (a[31] != b[31]))) return FP32_QNAN;
        if (fp32_is_inf(a)) return a;
        if (fp32_is_inf(b)) return b;
        if (fp32_is_zero(a) && fp32_is_zero(b)) return {a[31] & b[31], 31'd0};
        if (fp32_is_zero(a)) return b;
        if (fp32_is_zero(b)) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = fp32_exp(big) - fp32_exp(sml);
        mb = {fp32_sig(big), 3'd0};
        ms = {fp32_sig(sml), 3'd0};
        if (d > 26) begin
            ms = 27'd1;
        end else if (d > 0) begin
            ms = (ms >> d) | 27'(|(ms & ((27'd1 << d) - 27'd1)));
        end
        sum = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
        if (sum == 28'd0) return FP32_ZERO;
        return fp32_round_pack(big[31], fp32_exp(big) - 153, {22'd0, sum});
    endfunction

    logic [FP32_W-1:0] prod;
    logic [FP32_W-1:0] addend;

    always_comb begin
        prod   = fp32_mul(alpha_i, bravo_i);
        addend = clear_i ? FP32_ZERO : acc_i;
        sum_o  = fp32_add(addend, prod);
    end

`ifdef FP32_MAC_STATUS_EN
    assign nan_o = fp32_is_nan(sum_o);
    assign inf_o = fp32_is_inf(sum_o);
`endif

endmodule

// File: rtl/fp32_mac_vec.sv
// Vector of LANES FP32 multiply-accumulate lanes sharing one IDLE/CALC/HOLD controller.
// Sticky per-lane NaN/Inf flags on STATUS_O are built only with FP32_MAC_STATUS_EN.
module fp32_mac_vec
    import fp32_mac_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned CALC_CYCLES = 4
) (
    input  logic                    CLK_I,
    input  logic                    RSTL_I,
    input  logic                    IN_VALID_I,
    output logic                    IN_READY_O,
    input  logic [FP32_W*LANES-1:0] ALPHA_I,
    input  logic [FP32_W*LANES-1:0] BRAVO_I,
    input  logic                    CLEAR_I,
    input  logic                    LAST_I,
    output logic                    OUT_VALID_O,
    input  logic                    OUT_READY_I,
    output logic [FP32_W*LANES-1:0] DELTA_O,
    output logic [2*LANES-1:0]      STATUS_O
);

    localparam int unsigned CntW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

    mac_state_e              state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [FP32_W*LANES-1:0] alpha_q, alpha_d;
    logic [FP32_W*LANES-1:0] bravo_q, bravo_d;
    logic                    clear_q, clear_d;
    logic                    last_q, last_d;
    logic [FP32_W*LANES-1:0] acc_q, acc_d;
    logic [FP32_W*LANES-1:0] lane_sum;
    logic                    acc_upd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        alpha_d = alpha_q;
        bravo_d = bravo_q;
        clear_d = clear_q;
        last_d  = last_q;
        acc_d   = acc_q;
        acc_upd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (IN_VALID_I) begin
                    alpha_d = ALPHA_I;
                    bravo_d = BRAVO_I;
                    clear_d = CLEAR_I;
                    last_d  = LAST_I;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == CntW'(CALC_CYCLES - 1)) begin
                    acc_upd = 1'b1;
                    acc_d   = lane_sum;
                    cnt_d   = '0;
                    state_d = last_q ? StHold : StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHold: begin
                if (OUT_READY_I) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            alpha_q <= '0;
            bravo_q <= '0;
            clear_q <= 1'b0;
            last_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alpha_q <= alpha_d;
            bravo_q <= bravo_d;
            clear_q <= clear_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
        end
    end

    assign IN_READY_O  = (state_q == StIdle);
    assign OUT_VALID_O = (state_q == StHold);
    assign DELTA_O     = acc_q;

`ifdef FP32_MAC_STATUS_EN
    logic [2*LANES-1:0] status_q, status_d;
    logic [2*LANES-1:0] lane_flags;

    // A CLEAR beat restarts the flags before this beat's results are OR-ed in.
    always_comb begin
        status_d = status_q;
        if (acc_upd) status_d = (clear_q ? '0 : status_q) | lane_flags;
    end

    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) status_q <= '0;
        else         status_q <= status_d;
    end

    assign STATUS_O = status_q;
`else
    assign STATUS_O = '0;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fp32_mac_lane u_lane (
            .alpha_i (alpha_q[FP32_W*l +: FP32_W]),
            .bravo_i (bravo_q[FP32_W*l +: FP32_W]),
            .acc_i   (acc_q[FP32_W*l +: FP32_W]),
            .clear_i (clear_q),
`ifdef FP32_MAC_STATUS_EN
            .nan_o   (lane_flags[2*l+1]),
            .inf_o   (lane_flags[2*l]),
`endif
            .sum_o   (lane_sum[FP32_W*l +: FP32_W])
        );
    end

endmodule

// File: doc/fp32_mac_vec.md
FP32_MAC_VEC -- requirements
Module: fp32_mac_vec

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent FP32 MAC lanes (1..16).
REQ-002 SHALL have parameter CALC_CYCLES, default 4: cycles from operand acceptance to accumulator update (>=1).
REQ-003 SHALL have port CLK_I  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RSTL_I  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port IN_VALID_I  input  1  operand beat valid.
REQ-006 SHALL have port IN_READY_O  output  1  block can accept a beat.
REQ-007 SHALL have port ALPHA_I  input  32*LANES  multiplicand per lane; lane l at [32l+31:32l].
REQ-008 SHALL have port BRAVO_I  input  32*LANES  multiplier per lane, same packing.
REQ-009 SHALL have port CLEAR_I  input  1  beat starts a new accumulation (accumulator treated as +0.0).
REQ-010 SHALL have port LAST_I  input  1  beat is the final term; result is emitted.
REQ-011 SHALL have port OUT_VALID_O  output  1  DELTA_O valid.
REQ-012 SHALL have port OUT_READY_I  input  1  consumer accepts result.
REQ-013 SHALL have port DELTA_O  output  32*LANES  accumulated result per lane, same packing.
REQ-014 SHALL have port STATUS_O  output  2*LANES  per lane {nan,inf} sticky flags; lane l at [2l+1:2l].

Function
REQ-015 SHALL implement FSM states IDLE, CALC, HOLD.
REQ-016 SHALL drive IN_READY_O=1 only in IDLE; a beat is accepted on an edge with IN_VALID_I && IN_READY_O.
REQ-017 SHALL register ALPHA_I, BRAVO_I, CLEAR_I, LAST_I on acceptance and move IDLE->CALC; IN_VALID_I outside IDLE is ignored.
REQ-018 SHALL count in CALC; on the CALC_CYCLES-th edge after acceptance, per lane acc <= (CLEAR ? +0.0 : acc) + alpha*bravo, FP32 multiply then FP32 add, IEEE-754 single, round-to-nearest-even.
REQ-019 SHALL transition CALC->HOLD with OUT_VALID_O=1 on that same edge if captured LAST=1, else CALC->IDLE.
REQ-020 SHALL present DELTA_O = accumulator continuously; stable while OUT_VALID_O=1 && OUT_READY_I=0.
REQ-021 SHALL in HOLD, on edge with OUT_READY_I=1, clear OUT_VALID_O and go to IDLE; the accumulator is retained.
REQ-022 SHALL treat CLEAR_I=1 with LAST_I=1 as a single-product result.
REQ-023 SHALL allow a beat without CLEAR after emission to continue accumulating on the retained value.
REQ-024 SHALL give all lanes identical timing; lanes share one FSM.
REQ-025 SHALL sustain throughput of one beat per CALC_CYCLES+1 cycles (non-LAST), one result per CALC_CYCLES+2 cycles with OUT_READY_I=1.

Reset
REQ-026 SHALL on RSTL_I=0, at any state including mid-CALC or HOLD, asynchronously set: FSM=IDLE, counter=0, accumulators=0x00000000, operand regs=0, OUT_VALID_O=0, STATUS_O=0; IN_READY_O=1 once RSTL_I deasserts.
REQ-027 SHALL discard any in-flight beat on reset; no result is emitted for it.

Configuration
REQ-028 SHALL use macro FP32_MAC_STATUS_EN: defined -> per lane, nan flag set when any adder result is NaN, inf flag when any adder result is +/-Inf; both sticky, cleared (before OR-in) on a CLEAR beat update.
REQ-029 SHALL without FP32_MAC_STATUS_EN keep port STATUS_O, tied to all zeros, with no flag logic.

Structure
REQ-030 SHALL place state enum (IDLE, CALC, HOLD), FP32_ZERO=32'h00000000, FP32_QNAN=32'h7FC00000, FP32_W=32 in package fp32_mac_pkg.
REQ-031 SHALL use one sub-module fp32_mac_lane (existing combinational FP32 multiplier and adder, clear mux, status detect), instantiated LANES times by generate.

Verification
REQ-032 SHALL test LANES=4, CALC_CYCLES=4: lane0 1.0(0x3F800000)*2.0(0x40000000), CLEAR=LAST=1 -> OUT_VALID_O rises 4 edges after acceptance, lane0 DELTA_O=0x40000000.
REQ-033 SHALL test three beats 1.0*1.0 (first CLEAR, third LAST) -> single result 0x40400000 (3.0); OUT_VALID_O low after beats 1 and 2.
REQ-034 SHALL test OUT_READY_I=0 for 10 cycles in HOLD -> DELTA_O and OUT_VALID_O stable, IN_READY_O=0; OUT_READY_I=1 -> IDLE next edge.
REQ-035 SHALL test RSTL_I pulse at CALC cycle 2 -> OUT_VALID_O=0, DELTA_O=0, IN_READY_O=1, no result emitted.
REQ-036 SHALL test with FP32_MAC_STATUS_EN: lane1 0x7FC00000*1.0 CLEAR+LAST -> STATUS_O[3:2]=2'b10; next CLEAR beat 1.0*1.0 -> 2'b00; lane0 1e38*1e38 (0x7E967699) -> inf flag 2'b01.
